// File: rtl/quad_decoder.sv
// Quadrature encoder front end: A/B synchroniser, stability filter, Gray-code
// decoder and a 4-bit wrapping position counter with step/dir/carry outputs.
module quad_decoder #(
   parameter int unsigned FILT_LEN = 2
) (
   input  logic       clk,
   input  logic       mr_n,
   input  logic       a,
   input  logic       b,
   input  logic       en,
   input  logic       load_n,
   input  logic [3:0] d,
   input  logic       clr_err,
   output logic [3:0] q,
   output logic       step,
   output logic       dir,
   output logic       co,
   output logic       err
);

   localparam logic [4:0] FiltLen = 5'(FILT_LEN);

   logic [1:0] s1_q, s2_q;
   logic       v1_q, v2_q;
   logic [1:0] cand_q, cand_d;
   logic [3:0] cnt_q, cnt_d;
   logic [1:0] ph_q, ph_d;
   logic       acq_q, acq_d;
   logic [3:0] pos_q, pos_d;
   logic       step_q, step_d;
   logic       dir_q, dir_d;
   logic       co_q, co_d;
   logic       err_q, err_d;

   logic [4:0] run;
   logic [1:0] delta;
   logic       at_ph, accept, legal, illegal, up, count;

   // Position of a {a,b} state along the up sequence 00,01,11,10.
   function automatic logic [1:0] gidx(input logic [1:0] v);
      return {v[1], v[1] ^ v[0]};
   endfunction

   always_comb begin
      at_ph   = acq_q && (s2_q == ph_q);
      run     = (cnt_q != 4'd0 && s2_q == cand_q) ? {1'b0, cnt_q} + 5'd1 : 5'd1;
      // v2_q stays low until s2 holds a genuinely sampled value after reset.
      accept  = v2_q && !at_ph && (run >= FiltLen);
      delta   = gidx(s2_q) - gidx(ph_q);
      illegal = accept && acq_q && (delta == 2'd2);
      legal   = accept && acq_q && (delta != 2'd2);
      up      = (delta == 2'd1);
      count   = legal && en;

      cand_d = cand_q;
      cnt_d  = cnt_q;
      if (v2_q) begin
         if (at_ph || accept) begin
            cnt_d = 4'd0;
         end else begin
            cand_d = s2_q;
            cnt_d  = run[3:0];
         end
      end
      ph_d  = accept ? s2_q : ph_q;
      acq_d = acq_q | accept;

      step_d = count;
      dir_d  = count ? ~up : dir_q;
      co_d   = 1'b0;
      pos_d  = pos_q;
      if (!load_n) begin
         pos_d = d;
      end else if (count) begin
         if (up) begin
            pos_d = pos_q + 4'd1;
            co_d  = (pos_q == 4'd15);
         end else begin
            pos_d = pos_q - 4'd1;
            co_d  = (pos_q == 4'd0);
         end
      end

      err_d = illegal | (err_q & ~clr_err);
   end

   always_ff @(posedge clk or negedge mr_n) begin
      if (!mr_n) begin
         s1_q   <= 2'b00;
         s2_q   <= 2'b00;
         v1_q   <= 1'b0;
         v2_q   <= 1'b0;
         cand_q <= 2'b00;
         cnt_q  <= 4'd0;
         ph_q   <= 2'b00;
         acq_q  <= 1'b0;
         pos_q  <= 4'd0;
         step_q <= 1'b0;
         dir_q  <= 1'b0;
         co_q   <= 1'b0;
         err_q  <= 1'b0;
      end else begin
         s1_q   <= {a, b};
         s2_q   <= s1_q;
         v1_q   <= 1'b1;
         v2_q   <= v1_q;
         cand_q <= cand_d;
         cnt_q  <= cnt_d;
         ph_q   <= ph_d;
         acq_q  <= acq_d;
         pos_q  <= pos_d;
         step_q <= step_d;
         dir_q  <= dir_d;
         co_q   <= co_d;
         err_q  <= err_d;
      end
   end

   assign q    = pos_q;
   assign step = step_q;
   assign dir  = dir_q;
   assign co   = co_q;
   assign err  = err_q;

endmodule

// File: tb/tb_quad_decoder.sv
// Bench for quad_decoder: directed scenarios plus random A/B traffic, checked
// every cycle against a sample-history reference model.
module tb_quad_decoder;

   localparam int unsigned FILT_LEN = 2;

   logic       clk = 1'b0;
   logic       mr_n = 1'b0;
   logic       a = 1'b0, b = 1'b0;
   logic       en = 1'b1;
   logic       load_n = 1'b1;
   logic [3:0] d = 4'd0;
   logic       clr_err = 1'b0;
   logic [3:0] q;
   logic       step, dir, co, err;

   int checks = 0;
   int errors = 0;
   int nsteps = 0;
   int ncos = 0;

   quad_decoder #(.FILT_LEN(FILT_LEN)) dut (
      .clk(clk), .mr_n(mr_n), .a(a), .b(b), .en(en), .load_n(load_n), .d(d),
      .clr_err(clr_err), .q(q), .step(step), .dir(dir), .co(co), .err(err)
   );

   always #5 clk = ~clk;

   // Reference model state
   logic [1:0] pipe[$];
   logic [1:0] samp[$];
   bit         m_acq;
   logic [1:0] m_ph;
   logic [3:0] m_q;
   bit         m_step, m_dir, m_co, m_err;

   function automatic int gpos(input logic [1:0] v);
      case (v)
         2'b00:   return 0;
         2'b01:   return 1;
         2'b11:   return 2;
         default: return 3;
      endcase
   endfunction

   task automatic model_reset();
      pipe.delete();
      samp.delete();
      m_acq = 0; m_ph = 2'b00; m_q = 4'd0;
      m_step = 0; m_dir = 0; m_co = 0; m_err = 0;
   endtask

   task automatic model_edge();
      logic [1:0] s;
      bit have, acc, legal, ill, up, same;
      int dlt;
      m_step = 0; m_co = 0; legal = 0; ill = 0; up = 0; acc = 0; have = 0; s = 2'b00;
      if (pipe.size() == 2) begin
         s = pipe.pop_front();
         have = 1;
      end
      pipe.push_back({a, b});
      if (have) begin
         samp.push_back(s);
         if ((!m_acq || s != m_ph) && samp.size() >= FILT_LEN) begin
            same = 1;
            for (int i = samp.size() - FILT_LEN; i < samp.size(); i++)
               if (samp[i] != s) same = 0;
            acc = same;
         end
      end
      if (acc) begin
         samp.delete();
         if (!m_acq) begin
            m_acq = 1;
         end else begin
            dlt = (gpos(s) - gpos(m_ph) + 4) % 4;
            if (dlt == 2) ill = 1;
            else begin
               legal = 1;
               up = (dlt == 1);
            end
         end
         m_ph = s;
      end
      if (ill) m_err = 1;
      else if (clr_err) m_err = 0;
      if (legal && en) begin
         m_step = 1;
         m_dir = !up;
      end
      if (!load_n) m_q = d;
      else if (legal && en) begin
         if (up) begin
            m_co = (m_q == 4'd15);
            m_q = m_q + 4'd1;
         end else begin
            m_co = (m_q == 4'd0);
            m_q = m_q - 4'd1;
         end
      end
   endtask

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic chk_all(input string tag);
      chk({tag, ".q"},    {4'd0, q},    {4'd0, m_q});
      chk({tag, ".step"}, {7'd0, step}, {7'd0, m_step});
      chk({tag, ".dir"},  {7'd0, dir},  {7'd0, m_dir});
      chk({tag, ".co"},   {7'd0, co},   {7'd0, m_co});
      chk({tag, ".err"},  {7'd0, err},  {7'd0, m_err});
   endtask

   task automatic tick(input string tag);
      @(posedge clk);
      if (!mr_n) model_reset();
      else model_edge();
      @(negedge clk);
      chk_all(tag);
      if (step === 1'b1) nsteps++;
      if (co === 1'b1) ncos++;
   endtask

   task automatic do_reset(input logic [1:0] ab);
      @(negedge clk);
      {a, b} = ab;
      mr_n = 1'b0;
      model_reset();
      #1 chk_all("reset");
      @(negedge clk);
      mr_n = 1'b1;
   endtask

   logic [1:0] up_seq[4];
   int hold;

   initial begin
      up_seq = '{2'b01, 2'b11, 2'b10, 2'b00};
      model_reset();

      // Acquire: a=b=1 held through reset; no step, no err
      do_reset(2'b11);
      nsteps = 0;
      repeat (6) tick("acquire");
      chk("acquire_steps", 8'(nsteps), 8'd0);

      // Acquire 00, then 16 forward steps with one wrap
      do_reset(2'b00);
      repeat (5) tick("acq00");
      nsteps = 0; ncos = 0;
      for (int i = 0; i < 16; i++) begin
         {a, b} = up_seq[i % 4];
         repeat (5) tick("uprun");
      end
      chk("uprun_steps", 8'(nsteps), 8'd16);
      chk("uprun_co", 8'(ncos), 8'd1);
      chk("uprun_q", {4'd0, q}, 8'd0);

      // Down wrap 0 -> 15
      ncos = 0;
      {a, b} = 2'b10;
      repeat (5) tick("downwrap");
      chk("downwrap_q", {4'd0, q}, 8'd15);
      chk("downwrap_dir", {7'd0, dir}, 8'd1);
      chk("downwrap_co", 8'(ncos), 8'd1);
      {a, b} = 2'b00;
      repeat (5) tick("back00");

      // Glitches on b: 1-cycle rejected, 2-cycle gives up then down
      nsteps = 0;
      {a, b} = 2'b01; tick("glitch1");
      {a, b} = 2'b00; repeat (6) tick("glitch1");
      chk("glitch1_steps", 8'(nsteps), 8'd0);
      {a, b} = 2'b01; repeat (2) tick("glitch2");
      {a, b} = 2'b00; repeat (6) tick("glitch2");
      chk("glitch2_steps", 8'(nsteps), 8'd2);

      // Illegal jumps and err clearing; set wins over clear
      nsteps = 0;
      {a, b} = 2'b11; repeat (5) tick("illegal");
      chk("illegal_err", {7'd0, err}, 8'd1);
      {a, b} = 2'b00; repeat (3) tick("illegal2");
      clr_err = 1'b1; tick("illegal2_clr");
      clr_err = 1'b0;
      chk("setwins_err", {7'd0, err}, 8'd1);
      repeat (2) tick("illegal2");
      chk("illegal_steps", 8'(nsteps), 8'd0);
      clr_err = 1'b1; tick("clr");
      clr_err = 1'b0;
      chk("clr_err", {7'd0, err}, 8'd0);

      // Load coincident with an accepted up event
      {a, b} = 2'b01; repeat (3) tick("load");
      load_n = 1'b0; d = 4'd9; tick("load_edge");
      load_n = 1'b1;
      chk("load_q", {4'd0, q}, 8'd9);
      chk("load_step", {7'd0, step}, 8'd1);
      chk("load_co", {7'd0, co}, 8'd0);
      repeat (2) tick("load");

      // Count disabled
      en = 1'b0; nsteps = 0;
      {a, b} = 2'b11; repeat (5) tick("en0");
      {a, b} = 2'b10; repeat (5) tick("en0");
      chk("en0_steps", 8'(nsteps), 8'd0);
      chk("en0_q", {4'd0, q}, 8'd9);
      en = 1'b1;

      // Reset asserted mid-filter clears outputs immediately
      {a, b} = 2'b00; repeat (2) tick("midfilt");
      mr_n = 1'b0;
      model_reset();
      #1 chk_all("midreset");
      chk("midreset_q", {4'd0, q}, 8'd0);
      @(negedge clk);
      mr_n = 1'b1;

      // Random traffic
      for (int i = 0; i < 120; i++) begin
         {a, b} = 2'($urandom_range(0, 3));
         en = ($urandom_range(0, 4) != 0);
         load_n = ($urandom_range(0, 9) != 0);
         d = 4'($urandom);
         clr_err = ($urandom_range(0, 7) == 0);
         hold = $urandom_range(1, 6);
         for (int j = 0; j < hold; j++) begin
            tick("random");
            load_n = 1'b1;
            clr_err = 1'b0;
         end
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
